gf180mcu_fd_sc_mcu7t5v0__orn_acc: RTL and testbench

GF180MCU_FD_SC_MCU7T5V0__ORN_ACC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__orn_acc

---
 rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pkg.sv | 18 +
 rtl/gf180mcu_fd_sc_mcu7t5v0__orn_acc_ch.sv | 84 ++++++++
 rtl/gf180mcu_fd_sc_mcu7t5v0__orn_acc.sv | 74 +++++++
 tb/tb_gf180mcu_fd_sc_mcu7t5v0__orn_acc.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_pkg.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__orn_pkg
// Shared constants for the OR-reduce accumulator: default geometry of the
// block (inputs per channel, channel count, counter width) and the MODE
// encoding used by every channel.
// -----------------------------------------------------------------------------
package gf180mcu_fd_sc_mcu7t5v0__orn_pkg;

  localparam int ORN_WIDTH_DEF = 4;  // inputs OR-reduced per channel
  localparam int ORN_NCH_DEF   = 2;  // independent channels
  localparam int ORN_CNTW_DEF  = 8;  // per-channel hit counter width

  typedef enum logic {
    MODE_PASS   = 1'b0,  // Z is the registered OR of this cycle's inputs
    MODE_STICKY = 1'b1   // Z accumulates: once set it stays set until cleared
  } orn_mode_e;

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_acc_ch.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__orn_acc_ch
// One channel of the OR-reduce accumulator: reduces WIDTH inputs to a single
// hit bit, registers it (pass or sticky), counts hits with a saturating
// counter and flags saturation.
//
// Ports
//   CLK  in   rising-edge clock
//   RN   in   synchronous active-low reset (clears Z, CNT, SAT)
//   EN   in   update enable, low holds all state
//   MODE in   0 = pass, 1 = sticky
//   CLR  in   synchronous clear of Z, CNT, SAT (below RN, above EN)
//   A    in   WIDTH inputs of this channel
//   Z    out  registered OR result
//   CNT  out  saturating hit count
//   SAT  out  high while CNT is at its maximum
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__orn_acc_ch
  import gf180mcu_fd_sc_mcu7t5v0__orn_pkg::*;
#(
  parameter int WIDTH = ORN_WIDTH_DEF,
  parameter int CNTW  = ORN_CNTW_DEF
) (
  input  logic            CLK,
  input  logic            RN,
  input  logic            EN,
  input  logic            MODE,
  input  logic            CLR,
  input  logic [WIDTH-1:0] A,
  output logic            Z,
  output logic [CNTW-1:0] CNT,
  output logic            SAT
);

  localparam logic [CNTW-1:0] CNT_MAX = {CNTW{1'b1}};

  logic            raw;
  logic            z_d,   z_q;
  logic [CNTW-1:0] cnt_d, cnt_q;
  logic            sat_d, sat_q;

  always_comb begin
    raw   = |A;
    z_d   = z_q;
    cnt_d = cnt_q;
    sat_d = sat_q;
    if (CLR) begin
      // Clear wins over EN and discards this cycle's inputs entirely.
      z_d   = 1'b0;
      cnt_d = '0;
      sat_d = 1'b0;
    end else if (EN) begin
      // MODE is taken fresh each edge, so leaving sticky mode drops any
      // accumulated value immediately.
      if (orn_mode_e'(MODE) == MODE_STICKY) begin
        z_d = z_q | raw;
      end else begin
        z_d = raw;
      end
      if (raw && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNTW'(1);
      end
      // Flag rises on the same edge the counter lands on its maximum.
      sat_d = sat_q | (cnt_d == CNT_MAX);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RN) begin
      z_q   <= 1'b0;
      cnt_q <= '0;
      sat_q <= 1'b0;
    end else begin
      z_q   <= z_d;
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign Z   = z_q;
  assign CNT = cnt_q;
  assign SAT = sat_q;

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__orn_acc.sv
// -----------------------------------------------------------------------------
// gf180mcu_fd_sc_mcu7t5v0__orn_acc
// Multi-channel OR-reduce accumulator. Each of NCH channels OR-reduces its
// WIDTH-bit slice of A into a registered result Z[c] (pass or sticky) and a
// saturating hit counter CNT[c] with saturation flag SAT[c]. ZANY is the OR
// of the registered Z bits only.
//
// Ports
//   VDD, VSS  inout  power pins, only with USE_POWER_PINS
//   CLK       in     rising-edge clock
//   RN        in     synchronous active-low reset
//   EN        in     update enable
//   MODE      in     0 = pass, 1 = sticky
//   CLR       in     synchronous clear of all channels
//   A         in     NCH*WIDTH, channel c at A[c*WIDTH +: WIDTH]
//   Z         out    NCH registered per-channel results
//   ZANY      out    OR of Z
//   CNT       out    NCH*CNTW, channel c at CNT[c*CNTW +: CNTW]
//   SAT       out    NCH per-channel saturation flags
// -----------------------------------------------------------------------------
module gf180mcu_fd_sc_mcu7t5v0__orn_acc
  import gf180mcu_fd_sc_mcu7t5v0__orn_pkg::*;
#(
  parameter int WIDTH = ORN_WIDTH_DEF,
  parameter int NCH   = ORN_NCH_DEF,
  parameter int CNTW  = ORN_CNTW_DEF
) (
`ifdef USE_POWER_PINS
  inout  wire                  VDD,
  inout  wire                  VSS,
`endif
  input  logic                 CLK,
  input  logic                 RN,
  input  logic                 EN,
  input  logic                 MODE,
  input  logic                 CLR,
  input  logic [NCH*WIDTH-1:0] A,
  output logic [NCH-1:0]       Z,
  output logic                 ZANY,
  output logic [NCH*CNTW-1:0]  CNT,
  output logic [NCH-1:0]       SAT
);

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    gf180mcu_fd_sc_mcu7t5v0__orn_acc_ch #(
      .WIDTH (WIDTH),
      .CNTW  (CNTW)
    ) u_ch (
      .CLK  (CLK),
      .RN   (RN),
      .EN   (EN),
      .MODE (MODE),
      .CLR  (CLR),
      .A    (A[c*WIDTH +: WIDTH]),
      .Z    (Z[c]),
      .CNT  (CNT[c*CNTW +: CNTW]),
      .SAT  (SAT[c])
    );
  end

  // Driven from registered Z only, so A never reaches ZANY combinationally.
  assign ZANY = |Z;

`ifndef FUNCTIONAL
  // Multi-bit destinations need full-connection arcs from the single clock.
  specify
    (CLK *> Z)    = (1.0, 1.0);
    (CLK => ZANY) = (1.0, 1.0);
    (CLK *> CNT)  = (1.0, 1.0);
    (CLK *> SAT)  = (1.0, 1.0);
  endspecify
`endif

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__orn_acc.sv
module tb_gf180mcu_fd_sc_mcu7t5v0__orn_acc;

  // Main instance: 4 channels of 4 inputs, 8-bit counters.
  // Saturation instance: 2 channels of 4 inputs, 2-bit counters.
  logic        CLK = 1'b0;
  logic        RN, EN, MODE, CLR;
  logic [15:0] A;
  logic [3:0]  Z;
  logic        ZANY;
  logic [31:0] CNT;
  logic [3:0]  SAT;
  logic [7:0]  A_s;
  logic [1:0]  Z_s;
  logic        ZANY_s;
  logic [3:0]  CNT_s;
  logic [1:0]  SAT_s;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu7t5v0__orn_acc #(.WIDTH(4), .NCH(4), .CNTW(8)) dut (
    .CLK(CLK), .RN(RN), .EN(EN), .MODE(MODE), .CLR(CLR), .A(A),
    .Z(Z), .ZANY(ZANY), .CNT(CNT), .SAT(SAT)
  );

  gf180mcu_fd_sc_mcu7t5v0__orn_acc #(.WIDTH(4), .NCH(2), .CNTW(2)) dut_s (
    .CLK(CLK), .RN(RN), .EN(EN), .MODE(MODE), .CLR(CLR), .A(A_s),
    .Z(Z_s), .ZANY(ZANY_s), .CNT(CNT_s), .SAT(SAT_s)
  );

  typedef struct {
    logic [3:0]  z;
    logic [31:0] cnt;
    logic [3:0]  sat;
    logic        zany;
    logic [1:0]  zs;
    logic [3:0]  cnts;
    logic [1:0]  sats;
    logic        zanys;
  } exp_t;

  exp_t sb[$];

  // Reference state, kept as plain integers.
  logic mz[4];
  int   mcnt[4];
  logic msat[4];
  logic sz[2];
  int   scnt[2];
  logic ssat[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one reference channel by one clock edge.
  task automatic model_ch(input logic [3:0] a, input int maxc,
                          inout logic z, inout int cnt, inout logic sat);
    logic hit;
    hit = (a != 4'b0000);
    if (!RN || CLR) begin
      z = 1'b0; cnt = 0; sat = 1'b0;
    end else if (EN) begin
      z = MODE ? (z || hit) : hit;
      if (hit && cnt < maxc) cnt = cnt + 1;
      if (cnt == maxc) sat = 1'b1;
    end
  endtask

  // Predict the next edge, push it, clock, then pop and compare.
  task automatic tick();
    exp_t e, g;
    for (int c = 0; c < 4; c++) model_ch(A[c*4 +: 4], 255, mz[c], mcnt[c], msat[c]);
    for (int c = 0; c < 2; c++) model_ch(A_s[c*4 +: 4], 3, sz[c], scnt[c], ssat[c]);
    e.zany = 1'b0;
    for (int c = 0; c < 4; c++) begin
      e.z[c] = mz[c];
      e.cnt[c*8 +: 8] = 8'(mcnt[c]);
      e.sat[c] = msat[c];
      e.zany = e.zany | mz[c];
    end
    e.zanys = 1'b0;
    for (int c = 0; c < 2; c++) begin
      e.zs[c] = sz[c];
      e.cnts[c*2 +: 2] = 2'(scnt[c]);
      e.sats[c] = ssat[c];
      e.zanys = e.zanys | sz[c];
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    chk("sb_z",     32'(Z),      32'(g.z));
    chk("sb_cnt",   CNT,         g.cnt);
    chk("sb_sat",   32'(SAT),    32'(g.sat));
    chk("sb_zany",  32'(ZANY),   32'(g.zany));
    chk("sb_z_s",   32'(Z_s),    32'(g.zs));
    chk("sb_cnt_s", 32'(CNT_s),  32'(g.cnts));
    chk("sb_sat_s", 32'(SAT_s),  32'(g.sats));
    chk("sb_zany_s",32'(ZANY_s), 32'(g.zanys));
  endtask

  initial begin
    RN = 1'b1; EN = 1'b1; MODE = 1'b0; CLR = 1'b0; A = '0; A_s = '0;
    @(negedge CLK);

    // Reset overrides an active enable with every input high.
    RN = 1'b0; CLR = 1'b0; EN = 1'b1; A = 16'hFFFF; A_s = 8'hFF;
    tick();
    chk("rst_z", 32'(Z), 32'h0);
    chk("rst_cnt", CNT, 32'h0);
    chk("rst_sat", 32'(SAT), 32'h0);
    chk("rst_zany", 32'(ZANY), 32'h0);
    chk("rst_cnt_s", 32'(CNT_s), 32'h0);

    // Pass mode on channel 0.
    RN = 1'b1; MODE = 1'b0; A = 16'h0004; A_s = 8'h00;
    tick();
    chk("pass_z_hi", 32'(Z), 32'h1);
    chk("pass_zany_hi", 32'(ZANY), 32'h1);
    A = 16'h0000;
    tick();
    chk("pass_z_lo", 32'(Z), 32'h0);
    chk("pass_cnt0", 32'(CNT[7:0]), 32'd1);
    chk("pass_zany_lo", 32'(ZANY), 32'h0);

    // Sticky mode on channel 1, then drop back to pass.
    MODE = 1'b1; A = 16'h0010;
    tick();
    A = 16'h0000;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sticky_z1", 32'(Z[1]), 32'h1);
    end
    MODE = 1'b0;
    tick();
    chk("unstick_z1", 32'(Z[1]), 32'h0);
    chk("sticky_cnt1", 32'(CNT[15:8]), 32'd1);

    // Clear beats enable and sticky inputs.
    CLR = 1'b1; EN = 1'b1; MODE = 1'b1; A = 16'hFFFF; A_s = 8'hFF;
    tick();
    chk("clr_z", 32'(Z), 32'h0);
    chk("clr_cnt", CNT, 32'h0);
    CLR = 1'b0;
    tick();
    chk("pre_rst_z", 32'(Z), 32'hF);
    RN = 1'b0;
    tick();
    chk("mid_rst_z", 32'(Z), 32'h0);
    chk("mid_rst_cnt", CNT, 32'h0);
    RN = 1'b1;
    tick();
    // Hold: enable low with active inputs, then with idle inputs in pass mode.
    EN = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("hold_cnt", CNT, 32'h01010101);
    MODE = 1'b0; A = 16'h0000; A_s = 8'h00;
    tick();
    chk("hold_z", 32'(Z), 32'hF);
    chk("hold_sat_s", 32'(SAT_s), 32'h0);

    // Independence on channel 2, saturation on the 2-bit instance.
    EN = 1'b1; CLR = 1'b1;
    tick();
    CLR = 1'b0; A = 16'h0100; A_s = 8'h03;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i <= 5) begin
        chk("sat_cnt0", 32'(CNT_s[1:0]), (i < 3) ? 32'(i) : 32'd3);
        chk("sat_flag0", 32'(SAT_s[0]), (i >= 3) ? 32'h1 : 32'h0);
      end
    end
    chk("ind_cnt", CNT, 32'h000A0000);
    chk("ind_z", 32'(Z), 32'h4);
    chk("ind_sat_s1", 32'(SAT_s[1]), 32'h0);

    // Mixed random traffic against the reference.
    for (int i = 0; i < 80; i++) begin
      RN   = ($urandom_range(0, 15) != 0);
      CLR  = ($urandom_range(0, 11) == 0);
      EN   = ($urandom_range(0, 3) != 0);
      MODE = 1'($urandom_range(0, 1));
      A    = 16'($urandom & $urandom & $urandom);
      A_s  = 8'($urandom & $urandom);
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
